// File: rtl/spi_cmd_scheduler_if.sv
// Command-side and driver-side signal bundle for spi_cmd_scheduler.
// slave: the scheduler; master: command logic plus SPI driver.
interface spi_cmd_scheduler_if #(
    parameter int REG_WIDTH = 8
);
    logic                 wr_req;
    logic [REG_WIDTH-1:0] wr_addr;
    logic [REG_WIDTH-1:0] wr_data;
    logic                 wr_ack;
    logic                 rd_req;
    logic [7:0]           rd_start_addr;
    logic [7:0]           rd_count;
    logic                 rd_ack;
    logic [REG_WIDTH-1:0] rd_data;
    logic                 rd_data_valid;
    logic                 rd_done;
    logic                 busy;
    logic                 drv_new_command;
    logic                 drv_is_write;
    logic [REG_WIDTH-1:0] drv_addr;
    logic [REG_WIDTH-1:0] drv_write_data;
    logic [7:0]           drv_num_regs_to_read;
    logic [REG_WIDTH-1:0] drv_read_data;
    logic                 drv_write_complete;
    logic                 drv_read_complete;
    logic                 timeout;

    modport slave (
        input  wr_req, wr_addr, wr_data,
        input  rd_req, rd_start_addr, rd_count,
        input  drv_read_data, drv_write_complete, drv_read_complete,
        output wr_ack, rd_ack, rd_data, rd_data_valid, rd_done, busy,
        output drv_new_command, drv_is_write, drv_addr, drv_write_data,
        output drv_num_regs_to_read, timeout
    );

    modport master (
        output wr_req, wr_addr, wr_data,
        output rd_req, rd_start_addr, rd_count,
        output drv_read_data, drv_write_complete, drv_read_complete,
        input  wr_ack, rd_ack, rd_data, rd_data_valid, rd_done, busy,
        input  drv_new_command, drv_is_write, drv_addr, drv_write_data,
        input  drv_num_regs_to_read, timeout
    );
endinterface

// File: rtl/spi_cmd_scheduler.sv
// Round-robin write / burst-read scheduler feeding a single-register SPI driver.
// Optional per-transaction watchdog enabled by defining SPI_SCHED_TIMEOUT_EN.
module spi_cmd_scheduler #(
    parameter int REG_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rstn,
    spi_cmd_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 last_wr;
    logic                 is_write;
    logic [REG_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0] wdata;
    logic [REG_WIDTH-1:0] rdata;
    logic [7:0]           remaining;
    logic                 rd_valid;
    logic                 done_q;
    logic                 timeout_q;
    logic                 grant_wr;
    logic                 grant_rd;
    logic                 rd_zero;
    logic                 wr_fin;
    logic                 rd_fin;
    logic                 expire;

    // Acks are combinational so the requester sees them in the grant cycle.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (rstn && state == IDLE) begin
            if (bus.wr_req && (!bus.rd_req || !last_wr))
                grant_wr = 1'b1;
            else if (bus.rd_req)
                grant_rd = 1'b1;
        end
    end

    assign rd_zero = grant_rd && (bus.rd_count == 8'd0);
    assign wr_fin  = (state == WAIT) && is_write && bus.drv_write_complete;
    assign rd_fin  = (state == WAIT) && !is_write && bus.drv_read_complete;

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    assign expire = (state == WAIT) && !wr_fin && !rd_fin &&
                    (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wait_cnt <= '0;
        else if (state == ISSUE)
            wait_cnt <= CW'(1);
        else if (state == WAIT)
            wait_cnt <= wait_cnt + CW'(1);
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_wr || (grant_rd && !rd_zero))
                    state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (wr_fin)
                    state_nxt = IDLE;
                else if (rd_fin)
                    state_nxt = (remaining == 8'd1) ? IDLE : NEXT;
                else if (expire)
                    state_nxt = IDLE;
            end
            NEXT: state_nxt = ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            last_wr   <= 1'b0;
            is_write  <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rdata     <= '0;
            remaining <= 8'd0;
            rd_valid  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_valid  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= expire;
            if (grant_wr) begin
                last_wr  <= 1'b1;
                is_write <= 1'b1;
                addr     <= bus.wr_addr;
                wdata    <= bus.wr_data;
            end else if (grant_rd) begin
                last_wr   <= 1'b0;
                is_write  <= 1'b0;
                addr      <= REG_WIDTH'(bus.rd_start_addr);
                remaining <= bus.rd_count;
            end
            if (rd_fin) begin
                rdata     <= bus.drv_read_data;
                rd_valid  <= 1'b1;
                remaining <= remaining - 8'd1;
                done_q    <= (remaining == 8'd1);
            end
            // Address wraps naturally at the register width.
            if (state == NEXT)
                addr <= addr + REG_WIDTH'(1);
        end
    end

    assign bus.wr_ack               = grant_wr;
    assign bus.rd_ack               = grant_rd;
    assign bus.rd_data              = rdata;
    assign bus.rd_data_valid        = rd_valid;
    assign bus.rd_done              = done_q | rd_zero;
    assign bus.busy                 = (state != IDLE);
    assign bus.drv_new_command      = (state == ISSUE);
    assign bus.drv_is_write         = is_write;
    assign bus.drv_addr             = addr;
    assign bus.drv_write_data       = wdata;
    assign bus.drv_num_regs_to_read = 8'd1;
    assign bus.timeout              = timeout_q;
endmodule
